// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared constants and helpers for the multi-channel PWM
//                generator. Holds the register address map and the rule that
//                a programmed divider or period of zero behaves as one.
//  Revision    : 1.0  initial release
// ============================================================================
package pwm_pkg;

  // Register address map. DUTY[n] sits at ADDR_DUTY_BASE + n; address 3 is
  // reserved and ignored on write.
  localparam int ADDR_DIV       = 0;
  localparam int ADDR_PERIOD    = 1;
  localparam int ADDR_ENABLE    = 2;
  localparam int ADDR_DUTY_BASE = 4;

  // A limit of zero would leave a counter with no terminal value, so it is
  // treated as one. Callers zero-extend into 32 bits and truncate the result.
  function automatic logic [31:0] pwm_eff_limit(input logic [31:0] value);
    return (value == 32'd0) ? 32'd1 : value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_prescaler
//  Description : Clock divider for the PWM period counter. Counts
//                0..div_act-1 once per clk and raises tick combinationally on
//                the terminal count, returning to 0 on that same cycle.
//  Ports       : clk      in   system clock
//                reset    in   asynchronous active-low reset
//                div_act  in   active divider value (0 behaves as 1)
//                tick     out  one-clk strobe at the end of each divider cycle
//  Revision    : 1.0  initial release
// ============================================================================
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] div_act,
  output logic             tick
);

  // The top level resets the active divider to DEFAULT_DIV; it must fit the
  // register width or the reset value silently truncates.
  if (DEFAULT_DIV < 0 || longint'(DEFAULT_DIV) >= (longint'(1) << CNT_W)) begin : g_bad_default_div
    $error("pwm_prescaler: DEFAULT_DIV does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  logic [CNT_W-1:0] div_cnt_q;
  logic [CNT_W-1:0] div_cnt_d;
  logic [CNT_W-1:0] w_div_last;

  assign w_div_last = CNT_W'(pwm_eff_limit(32'(div_act)) - 32'd1);
  assign tick       = (div_cnt_q == w_div_last);

  // The active divider only changes on a period wrap, which always coincides
  // with a tick, so the counter is already back at 0 when a new value lands.
  always_comb begin
    div_cnt_d = div_cnt_q + c_one;
    if (tick) begin
      div_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pwm_multi_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_multi_gen
//  Description : Multi-channel PWM generator with a shared prescaler and
//                period counter. All configuration is double-buffered: writes
//                go to shadow registers which are copied into the active set
//                only when the period counter wraps, so a period is never cut
//                short or stretched by a reconfiguration.
//  Ports       : clk          in   system clock
//                reset        in   asynchronous active-low reset
//                wr_en        in   register write strobe
//                wr_addr      in   0 DIV, 1 PERIOD, 2 ENABLE, 4+n DUTY[n]
//                wr_data      in   write data (ENABLE uses [CHANNELS-1:0])
//                pwm          out  registered PWM outputs, XORed with POL
//                period_tick  out  one-clk pulse on the wrap cycle
//                cnt          out  current period count
//  Revision    : 1.0  initial release
// ============================================================================
module pwm_multi_gen
  import pwm_pkg::*;
#(
  parameter int                  CHANNELS       = 4,
  parameter int                  CNT_W          = 16,
  parameter int                  ADDR_W         = 4,
  parameter int                  DEFAULT_DIV    = 1000,
  parameter int                  DEFAULT_PERIOD = 100,
  parameter logic [CHANNELS-1:0] POL            = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [CNT_W-1:0]    wr_data,
  output logic [CHANNELS-1:0] pwm,
  output logic                period_tick,
  output logic [CNT_W-1:0]    cnt
);

  if ((ADDR_DUTY_BASE + CHANNELS) > (1 << ADDR_W)) begin : g_bad_addr_w
    $error("pwm_multi_gen: ADDR_W too narrow for the DUTY registers");
  end

  localparam logic [CNT_W-1:0]  c_def_div    = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0]  c_def_period = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0]  c_one        = CNT_W'(1);
  localparam logic [ADDR_W-1:0] c_addr_div   = ADDR_W'(ADDR_DIV);
  localparam logic [ADDR_W-1:0] c_addr_per   = ADDR_W'(ADDR_PERIOD);
  localparam logic [ADDR_W-1:0] c_addr_en    = ADDR_W'(ADDR_ENABLE);

  // Shared configuration: shadow (written by the bus) and active (in use).
  logic [CNT_W-1:0]    div_sh_q,    div_sh_d;
  logic [CNT_W-1:0]    div_act_q,   div_act_d;
  logic [CNT_W-1:0]    period_sh_q, period_sh_d;
  logic [CNT_W-1:0]    period_act_q, period_act_d;
  logic [CHANNELS-1:0] en_sh_q,     en_sh_d;
  logic [CHANNELS-1:0] en_act_q,    en_act_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;

  logic                w_tick;
  logic                w_wrap;
  logic [CNT_W-1:0]    w_period_last;

  pwm_prescaler #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .div_act (div_act_q),
    .tick    (w_tick)
  );

  assign w_period_last = CNT_W'(pwm_eff_limit(32'(period_act_q)) - 32'd1);
  assign w_wrap        = w_tick && (cnt_q == w_period_last);

  // The wrap term is combinational from registered state; gating with reset
  // keeps the pulse low while the block is held in reset even when the
  // defaults would otherwise wrap on every clk.
  assign period_tick = w_wrap && reset;
  assign cnt         = cnt_q;

  always_comb begin
    cnt_d        = cnt_q;
    div_sh_d     = div_sh_q;
    period_sh_d  = period_sh_q;
    en_sh_d      = en_sh_q;
    div_act_d    = div_act_q;
    period_act_d = period_act_q;
    en_act_d     = en_act_q;

    if (w_tick) begin
      cnt_d = w_wrap ? '0 : (cnt_q + c_one);
    end

    // Active copies take the pre-write shadow value; a write on the wrap
    // cycle is therefore deferred to the following wrap.
    if (w_wrap) begin
      div_act_d    = div_sh_q;
      period_act_d = period_sh_q;
      en_act_d     = en_sh_q;
    end

    if (wr_en) begin
      if (wr_addr == c_addr_div) begin
        div_sh_d = wr_data;
      end else if (wr_addr == c_addr_per) begin
        period_sh_d = wr_data;
      end else if (wr_addr == c_addr_en) begin
        en_sh_d = wr_data[CHANNELS-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      div_sh_q     <= c_def_div;
      div_act_q    <= c_def_div;
      period_sh_q  <= c_def_period;
      period_act_q <= c_def_period;
      en_sh_q      <= '0;
      en_act_q     <= '0;
    end else begin
      cnt_q        <= cnt_d;
      div_sh_q     <= div_sh_d;
      div_act_q    <= div_act_d;
      period_sh_q  <= period_sh_d;
      period_act_q <= period_act_d;
      en_sh_q      <= en_sh_d;
      en_act_q     <= en_act_d;
    end
  end

  // Per-channel duty registers and comparator. The output compares the
  // current count, so pwm trails cnt by one clk.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    localparam logic [ADDR_W-1:0] c_addr_duty = ADDR_W'(ADDR_DUTY_BASE + i);

    logic [CNT_W-1:0] duty_sh_q,  duty_sh_d;
    logic [CNT_W-1:0] duty_act_q, duty_act_d;
    logic             pwm_q,      pwm_d;

    always_comb begin
      duty_sh_d  = duty_sh_q;
      duty_act_d = duty_act_q;
      if (w_wrap) begin
        duty_act_d = duty_sh_q;
      end
      if (wr_en && (wr_addr == c_addr_duty)) begin
        duty_sh_d = wr_data;
      end
      pwm_d = (en_act_q[i] && (cnt_q < duty_act_q)) ^ POL[i];
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        duty_sh_q  <= '0;
        duty_act_q <= '0;
        pwm_q      <= POL[i];
      end else begin
        duty_sh_q  <= duty_sh_d;
        duty_act_q <= duty_act_d;
        pwm_q      <= pwm_d;
      end
    end

    assign pwm[i] = pwm_q;
  end

endmodule
`default_nettype wire
